lpif_txrx_x16_asym2_half_beat_packer: RTL and testbench
=======================================================

# lpif_txrx_x16_asym2_half_beat_packer

Sequential 1:2 beat packer that sits directly upstream of the x16 asym2 half-rate slave-side LPIF mapping stage. It accepts single-lane LPIF upstream beats (4-bit state, 2-bit protid, 256-bit data, 16-bit CRC plus qualifiers) over a valid/ready handshake. It pairs consecutive beats into the two-lane `ustrm_*` word consumed by that stage: first accepted beat in the low half, second in the high half. It also owns output buffering and backpressure toward the link layer.

## Interface
- Clocking: one clock; reset is asynchronous and active-low.
- PAD_TIMEOUT, default 16, idle cycles a lone low beat waits before a pad (only used with the Configuration macro), legal range 1..255.
- clk_wr  input  1  block clock; all state on rising edge.
- rst_wr_n  input  1  asynchronous active-low reset.
- beat_state  input  4  LPIF state for the offered beat.
- beat_protid  input  2  protocol id.
- beat_data  input  256  payload.
- beat_dvalid  input  1  data valid qualifier.
- beat_crc  input  16  CRC.
- beat_crc_valid  input  1  CRC valid qualifier.
- beat_valid  input  1  LPIF valid qualifier.
- beat_vld  input  1  handshake: beat offered.
- beat_rdy  output  1  handshake: beat accepted when beat_vld & beat_rdy.
- ustrm_state  output  8  [3:0] low beat, [7:4] high beat.
- ustrm_protid  output  2x2 = 4  [1:0] low, [3:2] high.
- ustrm_data  output  512  [255:0] low, [511:256] high.
- ustrm_dvalid, ustrm_crc_valid, ustrm_valid  output  2 each  bit0 low, bit1 high.
- ustrm_crc  output  32  [15:0] low, [31:16] high.
- ustrm_word_vld  output  1  packed word present.
- ustrm_word_rdy  input  1  downstream takes word when ustrm_word_vld & ustrm_word_rdy.
- pad_count  output  8  saturating count of padded words; zero when the macro is absent.

## Operation
- Registers:
  - Low-beat hold register (LO): 281 bits.
  - Output word register (OUT): 562 bits plus ustrm_word_vld.
  - Pairing FSM.
- FSM state WAIT_LO, reset state:
  - beat_rdy = 1.
  - An accepted beat is written to LO; go to WAIT_HI.
- FSM state WAIT_HI:
  - beat_rdy = !ustrm_word_vld | ustrm_word_rdy, i.e. OUT is empty or draining this cycle.
  - An accepted beat is combined with LO and written to OUT; ustrm_word_vld set; go to WAIT_LO.
- OUT drain: ustrm_word_vld clears on handshake unless reloaded in the same cycle. Simultaneous drain and load is legal; the new word replaces the old with no bubble.
- A low beat is never blocked by a full OUT. A second word's low half is captured while the first word is stalled.
- Output fields are driven only from OUT. No combinational path from beat_* to ustrm_*.
- beat_rdy depends combinationally only on FSM, ustrm_word_vld and ustrm_word_rdy, never on beat_vld.
- Field order within a beat is fixed: state, protid, data, dvalid, crc, crc_valid, valid.

## Timing
- Reset values (asserted asynchronously, released synchronously):
  - FSM = WAIT_LO; LO = 0; OUT = 0.
  - ustrm_word_vld = 0; pad_count = 0.
  - beat_rdy = 1 after reset.
- Latency: packed word visible on ustrm_* the cycle after the high beat handshake.
- Throughput: one word per two input cycles, sustained with ustrm_word_rdy held high.
- Downstream stall:
  - Up to one more low beat is accepted; then beat_rdy = 0 in WAIT_HI.
  - beat_rdy returns to 1 in the cycle ustrm_word_rdy rises.
- Reset mid-pair: a held low beat is discarded; no partial word is ever emitted.
- Once set, ustrm_word_vld and ustrm_* must hold stable until the handshake.

## Configuration
- LPIF_ASYM2_PACK_PAD_EN defined:
  - An 8-bit idle counter increments each cycle in WAIT_HI with no beat_vld. It clears on entry to WAIT_HI and on any beat_vld.
  - When the counter reaches PAD_TIMEOUT and OUT can accept, OUT loads LO plus an all-zero high half. The high-half valid bits are therefore 0.
  - On that pad: FSM goes to WAIT_LO and pad_count increments, saturating at 255.
  - If beat_vld is asserted in the expiry cycle, the real beat wins and no pad is emitted.
  - If OUT cannot accept at expiry, the counter holds at PAD_TIMEOUT until it can.
- LPIF_ASYM2_PACK_PAD_EN absent:
  - No counter exists; a low beat waits indefinitely.
  - pad_count is tied to 0.

## Test plan
- Reset then two beats with data A=0x11.., B=0x22.., beat_valid=1 and ustrm_word_rdy=1 -> one cycle after B: ustrm_data = {B,A}, ustrm_valid = 2'b11, ustrm_word_vld pulses for 1 cycle.
- Stream of 20 beats with ready held high -> 10 words in order with no gaps; beat_rdy constantly 1.
- Hold ustrm_word_rdy=0 after word 0 -> exactly one extra beat accepted, then beat_rdy=0 and ustrm_* stable. Raise ready -> word 0 drains and the next high beat loads in that same cycle.
- Assert rst_wr_n=0 in WAIT_HI holding beat A, then send C,D -> first word = {D,C}; A never appears.
- With the macro and PAD_TIMEOUT=4: single beat A then idle -> after 4 idle cycles the word {0,A} is loaded (ustrm_valid = 2'b01, pad_count=1). The same case with beat_vld at cycle 4 -> no pad, pad_count=0.
- Without the macro: single beat A then 300 idle cycles -> ustrm_word_vld stays 0, pad_count=0.

Source files
------------

// File: rtl/lpif_txrx_x16_asym2_half_beat_packer.sv
// lpif_txrx_x16_asym2_half_beat_packer: pairs two LPIF upstream beats into one two-lane ustrm word.
// Optional LO-beat timeout padding enabled by LPIF_ASYM2_PACK_PAD_EN.
module lpif_txrx_x16_asym2_half_beat_packer #(
  parameter int PAD_TIMEOUT = 16
) (
  input  logic         clk_wr,
  input  logic         rst_wr_n,
  input  logic [3:0]   beat_state,
  input  logic [1:0]   beat_protid,
  input  logic [255:0] beat_data,
  input  logic         beat_dvalid,
  input  logic [15:0]  beat_crc,
  input  logic         beat_crc_valid,
  input  logic         beat_valid,
  input  logic         beat_vld,
  output logic         beat_rdy,
  output logic [7:0]   ustrm_state,
  output logic [3:0]   ustrm_protid,
  output logic [511:0] ustrm_data,
  output logic [1:0]   ustrm_dvalid,
  output logic [1:0]   ustrm_crc_valid,
  output logic [1:0]   ustrm_valid,
  output logic [31:0]  ustrm_crc,
  output logic         ustrm_word_vld,
  input  logic         ustrm_word_rdy,
  output logic [7:0]   pad_count
);
  localparam int W = 281;
  typedef enum logic {WAIT_LO, WAIT_HI} state_t;
  state_t r_st;
  logic [W-1:0] w_beat, r_lo, w_olo, w_ohi;
  logic [2*W-1:0] r_out;
  logic r_vld, w_free, w_acc, w_pad, w_load;
  assign w_beat = {beat_state, beat_protid, beat_data, beat_dvalid, beat_crc, beat_crc_valid, beat_valid};
  assign w_free = !r_vld || ustrm_word_rdy;
  // low beats never wait on OUT; only the pairing beat needs room
  assign beat_rdy = (r_st == WAIT_LO) || w_free;
  assign w_acc = beat_vld && beat_rdy;
  assign w_load = (r_st == WAIT_HI) && (w_acc || w_pad);
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      r_st <= WAIT_LO;
      r_lo <= '0;
      r_out <= '0;
      r_vld <= 1'b0;
    end else begin
      r_vld <= w_load || (r_vld && !ustrm_word_rdy);
      if (w_load) begin
        r_out <= {w_acc ? w_beat : {W{1'b0}}, r_lo};
        r_st <= WAIT_LO;
      end else if (r_st == WAIT_LO && w_acc) begin
        r_lo <= w_beat;
        r_st <= WAIT_HI;
      end
    end
  end
`ifdef LPIF_ASYM2_PACK_PAD_EN
  localparam logic [7:0] PT = 8'(PAD_TIMEOUT);
  logic [7:0] r_idle, r_pad_cnt;
  // a real beat in the expiry cycle suppresses the pad
  assign w_pad = (r_st == WAIT_HI) && !beat_vld && (r_idle == PT) && w_free;
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      r_idle <= '0;
      r_pad_cnt <= '0;
    end else begin
      r_idle <= (r_st == WAIT_LO || beat_vld) ? 8'd0 : (r_idle == PT ? r_idle : r_idle + 8'd1);
      if (w_pad && r_pad_cnt != 8'hff) r_pad_cnt <= r_pad_cnt + 8'd1;
    end
  end
  assign pad_count = r_pad_cnt;
`else
  assign w_pad = 1'b0;
  assign pad_count = 8'(PAD_TIMEOUT) & 8'h00;
`endif
  assign w_olo = r_out[W-1:0];
  assign w_ohi = r_out[2*W-1:W];
  assign ustrm_state = {w_ohi[280:277], w_olo[280:277]};
  assign ustrm_protid = {w_ohi[276:275], w_olo[276:275]};
  assign ustrm_data = {w_ohi[274:19], w_olo[274:19]};
  assign ustrm_dvalid = {w_ohi[18], w_olo[18]};
  assign ustrm_crc = {w_ohi[17:2], w_olo[17:2]};
  assign ustrm_crc_valid = {w_ohi[1], w_olo[1]};
  assign ustrm_valid = {w_ohi[0], w_olo[0]};
  assign ustrm_word_vld = r_vld;
endmodule

// File: tb/tb_lpif_txrx_x16_asym2_half_beat_packer.sv
// tb_lpif_txrx_x16_asym2_half_beat_packer: scoreboard bench for the 1:2 beat packer.
module tb_lpif_txrx_x16_asym2_half_beat_packer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] beat_state = '0;
  logic [1:0] beat_protid = '0;
  logic [255:0] beat_data = '0;
  logic beat_dvalid = 1'b0, beat_crc_valid = 1'b0, beat_valid = 1'b0, beat_vld = 1'b0;
  logic [15:0] beat_crc = '0;
  logic beat_rdy, ustrm_word_vld, ustrm_word_rdy = 1'b1;
  logic [7:0] ustrm_state, pad_count;
  logic [3:0] ustrm_protid;
  logic [511:0] ustrm_data;
  logic [1:0] ustrm_dvalid, ustrm_crc_valid, ustrm_valid;
  logic [31:0] ustrm_crc;
  int errors = 0, checks = 0, cyc = 0, stalls = 0;
  logic [561:0] exp_q[$];
  logic [280:0] lo_m;
  bit have_lo = 0;
  lpif_txrx_x16_asym2_half_beat_packer #(.PAD_TIMEOUT(4)) dut (
    .clk_wr(clk), .rst_wr_n(rst_n), .beat_state(beat_state), .beat_protid(beat_protid),
    .beat_data(beat_data), .beat_dvalid(beat_dvalid), .beat_crc(beat_crc),
    .beat_crc_valid(beat_crc_valid), .beat_valid(beat_valid), .beat_vld(beat_vld),
    .beat_rdy(beat_rdy), .ustrm_state(ustrm_state), .ustrm_protid(ustrm_protid),
    .ustrm_data(ustrm_data), .ustrm_dvalid(ustrm_dvalid), .ustrm_crc_valid(ustrm_crc_valid),
    .ustrm_valid(ustrm_valid), .ustrm_crc(ustrm_crc), .ustrm_word_vld(ustrm_word_vld),
    .ustrm_word_rdy(ustrm_word_rdy), .pad_count(pad_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input logic [561:0] got, input logic [561:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  function automatic logic [280:0] mk(input logic [7:0] b);
    return {b[3:0], b[5:4], {32{b}}, 1'b1, b, ~b, 1'b1, 1'b1};
  endfunction
  function automatic logic [561:0] got_word();
    return {ustrm_state[7:4], ustrm_protid[3:2], ustrm_data[511:256], ustrm_dvalid[1],
            ustrm_crc[31:16], ustrm_crc_valid[1], ustrm_valid[1],
            ustrm_state[3:0], ustrm_protid[1:0], ustrm_data[255:0], ustrm_dvalid[0],
            ustrm_crc[15:0], ustrm_crc_valid[0], ustrm_valid[0]};
  endfunction
  // monitor: pops on every handshake, and checks that a stalled word holds still
  logic [561:0] held_w;
  bit held = 0;
  always @(negedge clk) begin
    if (!rst_n) held = 0;
    else if (ustrm_word_vld) begin
      if (held) chk("stall_stable", got_word(), held_w);
      if (ustrm_word_rdy) begin
        held = 0;
        if (exp_q.size() == 0) chk("unexpected_word", got_word(), '0);
        else chk("word", got_word(), exp_q.pop_front());
      end else begin
        held = 1;
        held_w = got_word();
      end
    end
  end
  task automatic send(input logic [280:0] b);
    int n = 0;
    {beat_state, beat_protid, beat_data, beat_dvalid, beat_crc, beat_crc_valid, beat_valid} = b;
    beat_vld = 1'b1;
    @(negedge clk);
    while (!beat_rdy && n < 200) begin
      @(negedge clk);
      n++;
      stalls++;
    end
    if (!beat_rdy) chk("send_timeout", 562'(beat_rdy), 562'(1));
    else begin
      @(posedge clk);
      if (have_lo) begin
        exp_q.push_back({b, lo_m});
        have_lo = 0;
      end else begin
        lo_m = b;
        have_lo = 1;
      end
    end
    #1 beat_vld = 1'b0;
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    have_lo = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1 chk("drain_empty", 562'(exp_q.size()), 562'(0));
  endtask
  initial begin
    int c0;
    logic [280:0] a, b;
    #12;
    chk("rst_beat_rdy", 562'(beat_rdy), 562'(1));
    chk("rst_word_vld", 562'(ustrm_word_vld), 562'(0));
    chk("rst_pad_count", 562'(pad_count), 562'(0));
    chk("rst_data", 562'(ustrm_data), 562'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    a = mk(8'h11);
    b = mk(8'h22);
    send(a);
    send(b);
    @(negedge clk);
    chk("pair_vld", 562'(ustrm_word_vld), 562'(1));
    chk("pair_data", 562'(ustrm_data), 562'({{32{8'h22}}, {32{8'h11}}}));
    chk("pair_valid", 562'(ustrm_valid), 562'(2'b11));
    @(negedge clk);
    chk("pair_pulse", 562'(ustrm_word_vld), 562'(0));
    @(posedge clk);
    #1 stalls = 0;
    c0 = cyc;
    for (int i = 0; i < 20; i++) send(mk(8'(8'h30 + i)));
    chk("stream_no_stall", 562'(stalls), 562'(0));
    chk("stream_cycles", 562'(cyc - c0), 562'(20));
    drain();
    // downstream stall: word 0 stalls, one extra low beat, then backpressure
    ustrm_word_rdy = 1'b0;
    send(mk(8'h51));
    send(mk(8'h52));
    send(mk(8'h53));
    {beat_state, beat_protid, beat_data, beat_dvalid, beat_crc, beat_crc_valid, beat_valid} = mk(8'h54);
    beat_vld = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_beat_rdy", 562'(beat_rdy), 562'(0));
    end
    @(posedge clk);
    #1 ustrm_word_rdy = 1'b1;
    #1 chk("ready_rise_beat_rdy", 562'(beat_rdy), 562'(1));
    @(negedge clk);
    chk("drain_and_load_vld", 562'(ustrm_word_vld), 562'(1));
    @(posedge clk);
    exp_q.push_back({mk(8'h54), lo_m});
    have_lo = 0;
    #1 beat_vld = 1'b0;
    @(negedge clk);
    chk("no_bubble", 562'(ustrm_word_vld), 562'(1));
    drain();
    // reset while holding a low beat: it must be discarded
    send(mk(8'hA1));
    do_reset();
    chk("midpair_rst_vld", 562'(ustrm_word_vld), 562'(0));
    send(mk(8'hC3));
    send(mk(8'hD4));
    drain();
`ifdef LPIF_ASYM2_PACK_PAD_EN
    send(mk(8'h61));
    exp_q.push_back({281'd0, lo_m});
    have_lo = 0;
    repeat (10) @(posedge clk);
    #1 chk("pad_count_one", 562'(pad_count), 562'(1));
    drain();
    do_reset();
    send(mk(8'h71));
    repeat (4) @(posedge clk);
    #1 send(mk(8'h72));
    repeat (10) @(posedge clk);
    #1 chk("pad_suppressed", 562'(pad_count), 562'(0));
    drain();
`else
    begin
      bit seen = 0;
      send(mk(8'h61));
      repeat (300) begin
        @(negedge clk);
        if (ustrm_word_vld) seen = 1;
      end
      chk("no_pad_vld", 562'(seen), 562'(0));
      chk("no_pad_count", 562'(pad_count), 562'(0));
    end
`endif
    chk("final_queue", 562'(exp_q.size()), 562'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
